// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy-logic pipeline stages.
// Holds the membership scale constants, the default pixel and membership
// widths, and the membership-triple struct exchanged with the defuzzifier.
package fuzzy_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int M_W_DEF   = 10;

  // Membership scale: 256 is full membership, 128 is half.
  localparam logic [M_W_DEF-1:0] M_ONE  = 10'd256;
  localparam logic [M_W_DEF-1:0] M_HALF = 10'd128;

  typedef struct packed {
    logic [M_W_DEF-1:0] min;
    logic [M_W_DEF-1:0] mid;
    logic [M_W_DEF-1:0] max;
  } m_triple_t;

endpackage

// File: rtl/fuzz_tri.sv
// Combinational triangular fuzzifier.
// Maps an 8-bit (gain-adjusted) gradient dg onto three memberships
// (low, mid, high) on the 0..256 scale. The three always sum to 256.
// Ports:
//   dg  in  8         gradient value
//   m   out triple    memberships {min, mid, max}
module fuzz_tri
  import fuzzy_pkg::*;
(
  input  logic [7:0] dg,
  output m_triple_t  m
);

  localparam logic [M_W_DEF-1:0] M_TWO = M_ONE << 1;

  logic [M_W_DEF-1:0] dg_wide;
  logic [M_W_DEF-1:0] dg2;

  assign dg_wide = M_W_DEF'(dg);
  assign dg2     = dg_wide << 1;

  always_comb begin
    m = '0;
    if (dg_wide < M_HALF) begin
      // Rising edge of mid, falling edge of min.
      m.min = M_ONE - dg2;
      m.mid = dg2;
    end else begin
      // Falling edge of mid, rising edge of max; 2*(dg-128) == 2*dg - 256.
      m.mid = M_TWO - dg2;
      m.max = dg2 - M_ONE;
    end
  end

endmodule

// File: rtl/fuzzify_pipe.sv
// Three-stage pipelined fuzzifier for a grayscale pixel stream.
// Stage 1 captures the pixel together with the previous accepted pixel,
// stage 2 forms the gain-adjusted horizontal gradient, stage 3 registers
// the triangular memberships onto the outputs. A single enable stalls
// every stage whenever the output is held.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pix_valid/ready/data  input pixel handshake and data
//   pix_sol               first pixel of a line (qualified by pix_valid)
//   m_valid/ready         output triple handshake
//   m_sol                 sol tag travelling with the triple
//   m_min/m_mid/m_max     memberships, 0..256 zero-extended to M_W
module fuzzify_pipe
  import fuzzy_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int M_W   = M_W_DEF,
  parameter int GAIN  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sol,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sol,
  output logic [M_W-1:0]   m_min,
  output logic [M_W-1:0]   m_mid,
  output logic [M_W-1:0]   m_max
);

  logic en;
  logic in_xfer;

  // Stage 1
  logic             s1_valid_reg;
  logic [PIX_W-1:0] s1_pix_reg;
  logic [PIX_W-1:0] s1_prev_reg;
  logic             s1_sol_reg;
  logic [PIX_W-1:0] prev_reg;
  logic             first_reg;

  // Stage 2
  logic             s2_valid_reg;
  logic [7:0]       s2_dg_reg;
  logic             s2_sol_reg;

  // Stage 3 (outputs)
  logic             m_valid_reg;
  logic             m_sol_reg;
  m_triple_t        m_tri_reg;

  logic [PIX_W-1:0]      d;
  logic [PIX_W+GAIN-1:0] d_shift;
  logic [7:0]            dg_next;
  m_triple_t             tri_next;

  assign en        = !m_valid_reg || m_ready;
  assign pix_ready = en;
  assign in_xfer   = pix_valid && en;

  // Gradient magnitude; a line start has no left neighbour, so d is 0.
  always_comb begin
    d = '0;
    if (!s1_sol_reg) begin
      d = (s1_pix_reg >= s1_prev_reg) ? (s1_pix_reg - s1_prev_reg)
                                      : (s1_prev_reg - s1_pix_reg);
    end
  end

  // Gain is applied in a widened word so overflow can be detected and
  // clamped to 255 rather than wrapping.
  assign d_shift = (PIX_W+GAIN)'(d) << GAIN;

  generate
    if (PIX_W + GAIN > 8) begin : g_sat
      assign dg_next = (|d_shift[PIX_W+GAIN-1:8]) ? 8'hFF : d_shift[7:0];
    end else begin : g_nosat
      assign dg_next = 8'(d_shift);
    end
  endgenerate

  fuzz_tri u_tri (
    .dg (s2_dg_reg),
    .m  (tri_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_pix_reg   <= '0;
      s1_prev_reg  <= '0;
      s1_sol_reg   <= 1'b0;
      prev_reg     <= '0;
      first_reg    <= 1'b1;
      s2_valid_reg <= 1'b0;
      s2_dg_reg    <= '0;
      s2_sol_reg   <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_sol_reg    <= 1'b0;
      m_tri_reg    <= '0;
    end else if (en) begin
      s1_valid_reg <= in_xfer;
      if (in_xfer) begin
        s1_pix_reg  <= pix_data;
        s1_prev_reg <= prev_reg;
        s1_sol_reg  <= pix_sol || first_reg;
        // prev only tracks accepted pixels, so gradients span bubbles.
        prev_reg    <= pix_data;
        first_reg   <= 1'b0;
      end
      s2_valid_reg <= s1_valid_reg;
      s2_dg_reg    <= dg_next;
      s2_sol_reg   <= s1_sol_reg;
      m_valid_reg  <= s2_valid_reg;
      m_sol_reg    <= s2_sol_reg;
      m_tri_reg    <= tri_next;
    end
  end

  assign m_valid = m_valid_reg;
  assign m_sol   = m_sol_reg;
  assign m_min   = M_W'(m_tri_reg.min);
  assign m_mid   = M_W'(m_tri_reg.mid);
  assign m_max   = M_W'(m_tri_reg.max);

endmodule

// File: tb/tb_fuzzify_pipe.sv
// Testbench for fuzzify_pipe: two instances (GAIN=0 and GAIN=1) driven by
// directed vectors and a random phase, checked against a behavioural model.
module tb_fuzzify_pipe;

  logic       clk;
  logic       rst;
  logic       pix_valid [2];
  logic       pix_ready [2];
  logic [7:0] pix_data  [2];
  logic       pix_sol   [2];
  logic       m_valid   [2];
  logic       m_ready   [2];
  logic       m_sol     [2];
  logic [9:0] m_min     [2];
  logic [9:0] m_mid     [2];
  logic [9:0] m_max     [2];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fuzzify_pipe #(.PIX_W(8), .M_W(10), .GAIN(0)) dut0 (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
    .pix_data(pix_data[0]), .pix_sol(pix_sol[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_sol(m_sol[0]),
    .m_min(m_min[0]), .m_mid(m_mid[0]), .m_max(m_max[0])
  );

  fuzzify_pipe #(.PIX_W(8), .M_W(10), .GAIN(1)) dut1 (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
    .pix_data(pix_data[1]), .pix_sol(pix_sol[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_sol(m_sol[1]),
    .m_min(m_min[1]), .m_mid(m_mid[1]), .m_max(m_max[1])
  );

  function void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: gradient, gain, saturation and triangle rules in plain integers.
  function automatic logic [30:0] model(int gain, int p, int prev, bit sol);
    int d, dg, mn, md, mx;
    d  = sol ? 0 : ((p > prev) ? p - prev : prev - p);
    dg = d << gain;
    if (dg > 255) dg = 255;
    if (dg < 128) begin
      mn = 256 - 2 * dg; md = 2 * dg; mx = 0;
    end else begin
      mn = 0; md = 512 - 2 * dg; mx = 2 * dg - 256;
    end
    return {sol, 10'(mn), 10'(md), 10'(mx)};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : mon
    logic [30:0] exp_q[$];
    logic [30:0] got_q[$];
    int          xfers = 0;
    bit          first_m = 1'b1;
    logic [7:0]  prev_m = '0;
    logic [30:0] e;

    always @(posedge clk) begin
      if (rst) begin
        exp_q.delete();
        first_m <= 1'b1;
        prev_m  <= '0;
      end else begin
        if (m_valid[gi] && m_ready[gi]) begin
          got_q.push_back({m_sol[gi], m_min[gi], m_mid[gi], m_max[gi]});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (pix_valid[gi] && pix_ready[gi]) begin
          exp_q.push_back(model(gi, int'(pix_data[gi]), int'(prev_m),
                                pix_sol[gi] || first_m));
          prev_m  <= pix_data[gi];
          first_m <= 1'b0;
          xfers   <= xfers + 1;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk("pix_ready", int'(pix_ready[gi]), int'(!m_valid[gi] || m_ready[gi]));
        if (m_valid[gi]) begin
          if (exp_q.size() == 0) begin
            chk("spurious_triple", 1, 0);
          end else begin
            e = exp_q[0];
            chk("m_sol", int'(m_sol[gi]), int'(e[30]));
            chk("m_min", int'(m_min[gi]), int'(e[29:20]));
            chk("m_mid", int'(m_mid[gi]), int'(e[19:10]));
            chk("m_max", int'(m_max[gi]), int'(e[9:0]));
          end
          chk("sum256", int'(m_min[gi]) + int'(m_mid[gi]) + int'(m_max[gi]), 256);
        end
      end
    end
  end

  function automatic int got_size(int k);
    return (k == 0) ? mon[0].got_q.size() : mon[1].got_q.size();
  endfunction

  function automatic logic [30:0] got_at(int k, int i);
    return (k == 0) ? mon[0].got_q[i] : mon[1].got_q[i];
  endfunction

  function void clear_got();
    mon[0].got_q.delete();
    mon[1].got_q.delete();
  endfunction

  task automatic put(int k, int d, bit s);
    bit ok;
    ok = 1'b0;
    pix_valid[k] = 1'b1;
    pix_data[k]  = 8'(d);
    pix_sol[k]   = s;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = pix_ready[k];
      @(posedge clk);
      #1;
    end
    if (!ok) chk("put_timeout", 0, 1);
    pix_valid[k] = 1'b0;
    pix_sol[k]   = 1'b0;
  endtask

  task automatic wait_out(int k, int n);
    int c;
    c = 0;
    while (got_size(k) < n && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (got_size(k) < n) chk("wait_out_timeout", got_size(k), n);
  endtask

  // Literal check of a captured triple.
  task automatic chk_tri(string name, int k, int idx, int s, int mn, int md, int mx);
    logic [30:0] v;
    n_tests++;
    if (got_size(k) <= idx) begin
      n_fail++;
      $display("FAIL %s: no triple at index %0d", name, idx);
    end else begin
      v = got_at(k, idx);
      if (v != {1'(s), 10'(mn), 10'(md), 10'(mx)}) begin
        n_fail++;
        $display("FAIL %s: got sol=%0d (%0d,%0d,%0d), expected sol=%0d (%0d,%0d,%0d)",
                 name, v[30], v[29:20], v[19:10], v[9:0], s, mn, md, mx);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pix_valid[k] = 1'b0; pix_data[k] = '0; pix_sol[k] = 1'b0; m_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_m_valid", int'(m_valid[k]), 0);
      chk("rst_m_sol", int'(m_sol[k]), 0);
      chk("rst_m_min", int'(m_min[k]), 0);
      chk("rst_m_mid", int'(m_mid[k]), 0);
      chk("rst_m_max", int'(m_max[k]), 0);
      chk("rst_pix_ready", int'(pix_ready[k]), 1);
    end
    @(posedge clk); #1;

    // First pixel, latency check
    clear_got();
    put(0, 100, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("latency_not_early", int'(m_valid[0]), 0);
    @(negedge clk);
    chk("latency_3", int'(m_valid[0]), 1);
    wait_out(0, 1);
    chk_tri("first_pixel", 0, 0, 1, 256, 0, 0);

    // Directed pairs, GAIN=0
    clear_got();
    put(0, 10, 1'b1);  put(0, 74, 1'b0);
    put(0, 200, 1'b1); put(0, 72, 1'b0);
    put(0, 0, 1'b1);   put(0, 255, 1'b0);
    put(0, 50, 1'b1);
    repeat (3) @(posedge clk);
    #1 put(0, 80, 1'b0);
    put(0, 90, 1'b1);  put(0, 20, 1'b1);
    wait_out(0, 10);
    chk_tri("d64", 0, 1, 0, 128, 128, 0);
    chk_tri("d128", 0, 3, 0, 0, 256, 0);
    chk_tri("d255", 0, 5, 0, 0, 2, 254);
    chk_tri("bubble_span", 0, 7, 0, 196, 60, 0);
    chk_tri("sol_a", 0, 8, 1, 256, 0, 0);
    chk_tri("sol_b", 0, 9, 1, 256, 0, 0);

    // GAIN=1 instance
    clear_got();
    put(1, 50, 1'b1); put(1, 150, 1'b0);
    put(1, 0, 1'b1);  put(1, 150, 1'b0);
    wait_out(1, 4);
    chk_tri("gain_first", 1, 0, 1, 256, 0, 0);
    chk_tri("gain_dg200", 1, 1, 0, 0, 112, 144);
    chk_tri("gain_sat", 1, 3, 0, 0, 2, 254);

    // Stream with a 5-cycle output stall
    clear_got();
    fork
      begin
        for (int i = 0; i < 10; i++) put(0, (i * 37 + 5) % 256, i == 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_ready[0] = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_pix_ready", int'(pix_ready[0]), 0);
          @(posedge clk);
        end
        #1 m_ready[0] = 1'b1;
      end
    join
    wait_out(0, 10);
    repeat (10) @(posedge clk);
    #1 chk("stall_count", got_size(0), 10);

    // Reset with three pixels in flight
    clear_got();
    m_ready[0] = 1'b0;
    put(0, 30, 1'b1); put(0, 60, 1'b0); put(0, 90, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_ready[0] = 1'b1;
    @(negedge clk);
    chk("rst_midflight_valid", int'(m_valid[0]), 0);
    repeat (5) @(posedge clk);
    #1 chk("rst_no_stale", got_size(0), 0);
    put(0, 120, 1'b0);
    wait_out(0, 1);
    chk_tri("post_rst_first", 0, 0, 1, 256, 0, 0);

    // Random traffic on both instances
    for (int c = 0; c < 60000 && (mon[0].xfers < 10000 || mon[1].xfers < 10000); c++) begin
      for (int k = 0; k < 2; k++) begin
        pix_valid[k] = ($urandom_range(3) != 0);
        case ($urandom_range(7))
          0:       pix_data[k] = 8'd0;
          1:       pix_data[k] = 8'd255;
          default: pix_data[k] = 8'($urandom_range(255));
        endcase
        pix_sol[k] = ($urandom_range(7) == 0);
        m_ready[k] = ($urandom_range(3) != 0);
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      pix_valid[k] = 1'b0; pix_sol[k] = 1'b0; m_ready[k] = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("random_xfers0", int'(mon[0].xfers >= 10000), 1);
    chk("random_xfers1", int'(mon[1].xfers >= 10000), 1);
    chk("drain0", mon[0].exp_q.size(), 0);
    chk("drain1", mon[1].exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
